// File: rtl/track_pkg.sv
// Shared types and helpers for the LED-bar sprite mover: mode encoding,
// LFSR feedback taps and the sprite mask builder.
package track_pkg;

  typedef enum logic [1:0] {
    MODE_SEQ    = 2'b00,
    MODE_RAND   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } track_mode_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Bits pos-w+1..pos set, clipped to an n-LED bar (n <= 64).
  function automatic logic [63:0] sprite_mask(int pos, int w, int n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++)
      if (i < n && i <= pos && i > pos - w) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/target_led_track_if.sv
// Control and display bundle of the sprite mover; the game logic is the
// master, target_led_track is the slave.
interface target_led_track_if #(
  parameter int N_LED = 16
);
  logic [1:0]               mode_sel;
  logic                     mode_wr;
  logic                     hold;
  logic [$clog2(N_LED)-1:0] pos;
  logic [N_LED-1:0]         led;
  logic                     moved;
  logic [2:0]               level;

  modport master (output mode_sel, mode_wr, hold, input pos, led, moved, level);
  modport slave  (input mode_sel, mode_wr, hold, output pos, led, moved, level);
endinterface

// File: rtl/track_tick_gen.sv
// Move prescaler: pulses tick once every thr clocks, frozen while hold is
// high and restarted from zero by clr.
module track_tick_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] thr,
  input  logic             hold,
  input  logic             clr,
  output logic             tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == thr - CNT_W'(1)) && !hold;
    cnt_d = cnt_q;
    if (clr || tick) cnt_d = '0;
    else if (!hold)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/target_led_track.sv
// LED-bar sprite mover: SEQ / LFSR-random / BOUNCE position update once per
// prescaler tick. Define TRACK_SPEEDUP_EN to halve the move period per level.
module target_led_track
  import track_pkg::*;
#(
  parameter int          N_LED         = 16,
  parameter int          SPRITE_W      = 3,
  parameter int          STEP          = 2,
  parameter int          TICK_DIV      = 50_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          SPEEDUP_MOVES = 8,
  parameter int          MAX_LEVEL     = 4
) (
  input logic              clk,
  input logic              rst,
  target_led_track_if.slave bus
);
  localparam int PW      = $clog2(N_LED);
  localparam int SW      = PW + 2;
  localparam int CNT_W   = $clog2(TICK_DIV + 1);
  localparam int POS_MIN = SPRITE_W - 1;
  localparam int POS_MAX = N_LED - 1;
  localparam int RANGE   = POS_MAX - POS_MIN + 1;

  localparam logic signed [SW-1:0] MIN_S   = SW'(POS_MIN);
  localparam logic signed [SW-1:0] MAX_S   = SW'(POS_MAX);
  localparam logic signed [SW-1:0] STEP_S  = SW'(STEP);
  localparam logic [PW-1:0]        MIN_U   = PW'(POS_MIN);
  localparam logic [PW-1:0]        MAX_U   = PW'(POS_MAX);
  localparam logic [15:0]          RANGE_U = 16'(RANGE);

  if (N_LED < SPRITE_W + 1 || SPRITE_W < 1 || STEP < 1 || STEP > N_LED - SPRITE_W ||
      TICK_DIV < 2 || LFSR_SEED == 16'h0 || N_LED > 64 || MAX_LEVEL > 7 ||
      SPEEDUP_MOVES < 1) begin : g_bad_cfg
    $error("target_led_track: illegal parameter set");
  end

  track_mode_e      mode_q, mode_d;
  logic             dir_up_q, dir_up_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             moved_q, moved_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] thr;
  logic             tick;

  track_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .thr  (thr),
    .hold (bus.hold),
    .clr  (bus.mode_wr),
    .tick (tick)
  );

`ifdef TRACK_SPEEDUP_EN
  localparam int MC_W = $clog2(SPEEDUP_MOVES + 1);
  logic [MC_W-1:0] mcnt_q, mcnt_d;
  logic [2:0]      level_q, level_d;

  always_comb begin
    mcnt_d  = mcnt_q;
    level_d = level_q;
    if (bus.mode_wr) begin
      mcnt_d  = '0;
      level_d = '0;
    end else if (tick) begin
      if (mcnt_q == MC_W'(SPEEDUP_MOVES - 1)) begin
        mcnt_d = '0;
        if (level_q < 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
      end else begin
        mcnt_d = mcnt_q + MC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt_q  <= '0;
      level_q <= '0;
    end else begin
      mcnt_q  <= mcnt_d;
      level_q <= level_d;
    end
  end

  assign thr       = CNT_W'(TICK_DIV) >> level_q;
  assign bus.level = level_q;
`else
  assign thr       = CNT_W'(TICK_DIV);
  assign bus.level = 3'd0;
`endif

  // Widened signed copies so pos +/- STEP can be range-checked without wrap.
  logic signed [SW-1:0] pos_s, up_s, dn_s;
  logic [PW-1:0]        cand;

  always_comb begin
    pos_s    = $signed({2'b00, pos_q});
    up_s     = pos_s + STEP_S;
    dn_s     = pos_s - STEP_S;
    cand     = MIN_U + PW'(lfsr_q % RANGE_U);
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    mode_d   = mode_q;
    dir_up_d = dir_up_q;
    pos_d    = pos_q;
    moved_d  = 1'b0;
    if (bus.mode_wr) begin
      mode_d   = track_mode_e'(bus.mode_sel);
      dir_up_d = 1'b1;
    end else if (tick) begin
      moved_d = 1'b1;
      case (mode_q)
        MODE_RAND: begin
          if (cand != pos_q)       pos_d = cand;
          else if (pos_q == MAX_U) pos_d = MIN_U;
          else                     pos_d = pos_q + PW'(1);
        end
        MODE_BOUNCE: begin
          if (dir_up_q) begin
            if (up_s > MAX_S) begin
              pos_d    = MAX_U;
              dir_up_d = 1'b0;
            end else begin
              pos_d = up_s[PW-1:0];
            end
          end else begin
            if (dn_s < MIN_S) begin
              pos_d    = MIN_U;
              dir_up_d = 1'b1;
            end else begin
              pos_d = dn_s[PW-1:0];
            end
          end
        end
        default: pos_d = (up_s > MAX_S) ? MIN_U : up_s[PW-1:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_SEQ;
      dir_up_q <= 1'b1;
      pos_q    <= MIN_U;
      moved_q  <= 1'b0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      mode_q   <= mode_d;
      dir_up_q <= dir_up_d;
      pos_q    <= pos_d;
      moved_q  <= moved_d;
      lfsr_q   <= lfsr_d;
    end
  end

  logic [63:0] mask_full;
  logic        unused_mask;
  always_comb mask_full = sprite_mask(int'(pos_q), SPRITE_W, N_LED);
  assign unused_mask = |mask_full;

  assign bus.led   = mask_full[N_LED-1:0];
  assign bus.pos   = pos_q;
  assign bus.moved = moved_q;
endmodule

// File: tb/tb_target_led_track.sv
// Scoreboard bench for target_led_track: a spec-level model predicts each
// move (cycle, pos, level) and a negedge monitor matches the DUT pulses.
module tb_target_led_track;
  localparam int N = 16, W = 3, STEP = 2, SPM = 8, MAXL = 4;
  localparam int PMIN = W - 1, PMAX = N - 1, RNG = PMAX - PMIN + 1;
`ifdef TRACK_SPEEDUP_EN
  localparam int TDIV = 64;
`else
  localparam int TDIV = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  target_led_track_if #(.N_LED(N)) bus();

  target_led_track #(
    .N_LED(N), .SPRITE_W(W), .STEP(STEP), .TICK_DIV(TDIV), .LFSR_SEED(16'hACE1),
    .SPEEDUP_MOVES(SPM), .MAX_LEVEL(MAXL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {int cyc; int pos; int level;} exp_t;
  exp_t exp_q[$];

  // Reference model: plain integer arithmetic on the movement rules.
  int cyc = 0, m_total = 0;
  int m_cnt = 0, m_pos = PMIN, m_mode = 0, m_level = 0, m_moves = 0, m_thr, m_nxt;
  bit m_up = 1'b1;
  int unsigned m_lfsr = 32'hACE1;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_cnt = 0; m_pos = PMIN; m_mode = 0; m_level = 0; m_moves = 0;
      m_up = 1'b1; m_lfsr = 32'hACE1;
      exp_q.delete();
    end else begin
      cyc++;
      m_thr = TDIV >> m_level;
      if (bus.mode_wr) begin
        m_mode = (bus.mode_sel == 2'd3) ? 0 : int'(bus.mode_sel);
        m_cnt = 0; m_up = 1'b1; m_level = 0; m_moves = 0;
      end else if (!bus.hold) begin
        if (m_cnt < m_thr - 1) m_cnt++;
        else begin
          m_cnt = 0;
          case (m_mode)
            1: begin
              m_nxt = PMIN + int'(m_lfsr % RNG);
              if (m_nxt == m_pos) m_nxt = (m_pos == PMAX) ? PMIN : m_pos + 1;
            end
            2: begin
              if (m_up) begin
                if (m_pos + STEP > PMAX) begin m_nxt = PMAX; m_up = 1'b0; end
                else m_nxt = m_pos + STEP;
              end else begin
                if (m_pos - STEP < PMIN) begin m_nxt = PMIN; m_up = 1'b1; end
                else m_nxt = m_pos - STEP;
              end
            end
            default: m_nxt = (m_pos + STEP > PMAX) ? PMIN : m_pos + STEP;
          endcase
          m_pos = m_nxt;
          m_total++;
`ifdef TRACK_SPEEDUP_EN
          m_moves++;
          if (m_moves == SPM) begin
            m_moves = 0;
            if (m_level < MAXL) m_level++;
          end
`endif
          exp_q.push_back('{cyc, m_pos, m_level});
        end
      end
      m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'hB400 : 32'h0);
    end
  end

  // Monitor
  int  prev_pos = -1, mon_moves = 0, mon_last_cyc = 0;
  bit  rand_phase = 1'b0;
  bit [15:0] seen = '0;
  exp_t e;

  initial forever begin
    @(negedge clk);
    if (!rst && bus.moved) begin
      mon_moves++;
      mon_last_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_move: got pos %0d at cycle %0d, expected no move", bus.pos, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("move_cycle", cyc, e.cyc);
        chk("pos", bus.pos, e.pos);
        chk("led", bus.led, ((1 << W) - 1) << (e.pos - W + 1));
        chk("level", bus.level, e.level);
      end
      chk("pos_in_range", (bus.pos >= PMIN && bus.pos <= PMAX), 1);
      if (rand_phase) begin
        chk("rand_changes", (int'(bus.pos) != prev_pos), 1);
        seen[bus.pos] = 1'b1;
      end
      prev_pos = bus.pos;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_moves(input int n, input string tag);
    int target = m_total + n;
    int budget = n * TDIV + 200;
    while (m_total < target && budget > 0) begin step(1); budget--; end
    if (m_total < target) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_%s: got %0d moves, expected %0d", tag, m_total, target);
    end
  endtask

  task automatic write_mode(input logic [1:0] m);
    bus.mode_sel = m;
    bus.mode_wr  = 1'b1;
    step(1);
    bus.mode_wr  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pos"}, bus.pos, PMIN);
    chk({tag, "_led"}, bus.led, 16'h0007);
    chk({tag, "_moved"}, bus.moved, 0);
    chk({tag, "_level"}, bus.level, 0);
  endtask

  int snap, rel_cyc, wr_cyc, budget;

  initial begin
    bus.mode_sel = 2'd0; bus.mode_wr = 1'b0; bus.hold = 1'b0;
    rst = 1'b1;
    step(3);
    check_reset_vals("reset");
    rst = 1'b0;

    wait_moves(10, "seq");

    // reset right after a move edge, while moved is high
    rst = 1'b1; #1;
    check_reset_vals("rst_async");
    step(2);
    rst = 1'b0;

    write_mode(2'd2);
    wait_moves(30, "bounce");

    write_mode(2'd1);
    rand_phase = 1'b1;
    wait_moves(1000, "rand");
    step(1);
    rand_phase = 1'b0;
    chk("rand_coverage", $countones(seen), RNG);

    // hold mid-period: count must freeze, not restart
    write_mode(2'd3);
    wait_moves(2, "hold_pre");
    step(1);
    bus.hold = 1'b1;
    snap = mon_moves;
    step(20);
    chk("hold_no_move", mon_moves - snap, 0);
    bus.hold = 1'b0;
    rel_cyc = cyc;
    wait_moves(1, "hold_post");
    step(1);
    chk("hold_resume_gap", mon_last_cyc - rel_cyc, (TDIV >> m_level) - 1);

    // mode_wr landing on a tick edge
    budget = 500;
    while (m_cnt != (TDIV >> m_level) - 1 && budget > 0) begin step(1); budget--; end
    chk("tick_align_found", (budget > 0), 1);
    snap = mon_moves;
    wr_cyc = cyc + 1;
    write_mode(2'd2);
    step(1);
    chk("modewr_tick_no_move", mon_moves - snap, 0);
    wait_moves(1, "modewr_post");
    step(1);
    chk("modewr_next_gap", mon_last_cyc - wr_cyc, TDIV);

    // reset mid-period
    wait_moves(1, "rst_mid_pre");
    step(2);
    rst = 1'b1; #1;
    check_reset_vals("rst_mid");
    step(2);
    rst = 1'b0;
    wait_moves(6, "after_rst");

    // long SEQ run: exercises level steps when the speed-up build is used
    write_mode(2'd0);
    wait_moves(45, "speedup");

    step(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
